// File: rtl/uart_rcvr_if.sv
// Parallel-side and serial-line signals of the uart_rcvr block.
// master: the receiver itself; slave: the line driver / word consumer.
interface uart_rcvr_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  frame_err;
  logic                  busy;

  modport master (
    input  rx_data,
    output data_out,
    output valid_out,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_data,
    input  data_out,
    input  valid_out,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rcvr.sv
// 8N1 UART receiver with mid-bit sampling, framing-error and false-start detection.
// Optional even-parity check when UART_RCVR_PARITY_EN is defined.
module uart_rcvr #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  uart_rcvr_if.master bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef UART_RCVR_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_PARITY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic                  rx_s;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bitc_q, bitc_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q, busy_d;
`ifdef UART_RCVR_PARITY_EN
  logic                  pbad_q, pbad_d;
`endif

  assign rx_s = sync2_q;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx_data;
      sync2_q <= sync1_q;
    end
  end

  // State, counters, shifter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bitc_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bitc_q  <= bitc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RCVR_PARITY_EN
      pbad_q  <= pbad_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bitc_d  = bitc_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RCVR_PARITY_EN
    pbad_d  = pbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          baud_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          bitc_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_END) begin
          shift_d = DATA_WIDTH'({rx_s, shift_q} >> 1);
          baud_d  = '0;
          bitc_d  = bitc_q + CW'(1);
          if (bitc_q == LAST_BIT) begin
`ifdef UART_RCVR_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_RCVR_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_END) begin
          pbad_d  = rx_s ^ (^shift_q);
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BAUD_END) begin
          baud_d = '0;
          if (!rx_s) begin
            // Held-low stop bit: wait for the line to recover before re-arming.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_RCVR_PARITY_EN
          end else if (pbad_q) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bitc_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed bench for uart_rcvr: frame-level model predicts each pulse cycle and
// the data_out value, checked every cycle, plus hand-computed latency/data pins.
module tb_uart_rcvr;
  localparam int CPB = 8;
`ifdef UART_RCVR_PARITY_EN
  localparam int NBITS    = 11;
  localparam int HAND_LAT = 87;
`else
  localparam int NBITS    = 10;
  localparam int HAND_LAT = 79;
`endif
  // Drive-to-pulse delay: 2 sync cycles + half bit + data/parity bits + stop, then registered.
  localparam int LAT   = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;
  localparam int FRAME = NBITS * CPB;

  typedef struct { int c; logic err; logic [7:0] d; } ev_t;
  typedef struct { int c; logic [7:0] d; } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_from = -10;
  int   busy_to = -10;
  int   d;
  logic [7:0] data_exp;
  ev_t  exp_q[$];
  obs_t vq[$];
  int   fq[$];

  uart_rcvr_if #(.DATA_WIDTH(8)) bus ();
  uart_rcvr #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    logic ev;
    logic ee;
    ev = 1'b0;
    ee = 1'b0;
    if (reset) begin
      data_exp = 8'h00;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        if (exp_q[0].err) ee = 1'b1;
        else begin
          ev = 1'b1;
          data_exp = exp_q[0].d;
        end
        exp_q.delete(0);
      end
      chk("valid_out", bus.valid_out, ev);
      chk("frame_err", bus.frame_err, ee);
      chk("data_out", bus.data_out, data_exp);
      if (bus.valid_out) vq.push_back('{cyc, bus.data_out});
      if (bus.frame_err) fq.push_back(cyc);
      if (cyc >= busy_from && cyc <= busy_to) chk("busy_high", bus.busy, 1);
      else if (cyc == busy_to + 1) chk("busy_low", bus.busy, 0);
    end
  end

  task automatic hold(input logic b, input int n);
    bus.rx_data = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

`ifdef UART_RCVR_PARITY_EN
  task automatic send_p(input logic [7:0] b, input logic stop_v, input logic par_v, output int dc);
    dc = cyc;
    exp_q.push_back('{dc + LAT, (!stop_v) || (par_v != ^b), b});
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(par_v, CPB);
    hold(stop_v, CPB);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, output int dc);
    send_p(b, stop_v, ^b, dc);
  endtask
`else
  task automatic send(input logic [7:0] b, input logic stop_v, output int dc);
    dc = cyc;
    exp_q.push_back('{dc + LAT, !stop_v, b});
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, CPB);
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.rx_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    idle(100);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_no_valid", vq.size(), 0);

    // Single clean frame with busy window check.
    vq.delete();
    busy_from = cyc + 3;
    busy_to   = cyc + LAT - 1;
    send(8'hA5, 1'b1, d);
    idle(10);
    busy_from = -10;
    busy_to   = -10;
    chk("a5_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("a5_latency", vq[0].c - d, HAND_LAT);
      chk("a5_data", vq[0].d, 8'hA5);
    end

    // Back-to-back frames, no idle gap.
    vq.delete();
    send(8'h00, 1'b1, d);
    send(8'hFF, 1'b1, d);
    send(8'h3C, 1'b1, d);
    idle(10);
    chk("b2b_count", vq.size(), 3);
    if (vq.size() == 3) begin
      chk("b2b_gap1", vq[1].c - vq[0].c, FRAME);
      chk("b2b_gap2", vq[2].c - vq[1].c, FRAME);
      chk("b2b_d0", vq[0].d, 8'h00);
      chk("b2b_d1", vq[1].d, 8'hFF);
      chk("b2b_d2", vq[2].d, 8'h3C);
    end

    // Two-cycle low glitch: false start.
    vq.delete();
    fq.delete();
    busy_from = cyc + 3;
    busy_to   = cyc + 6;
    hold(1'b0, 2);
    idle(20);
    busy_from = -10;
    busy_to   = -10;
    chk("glitch_valid", vq.size(), 0);
    chk("glitch_ferr", fq.size(), 0);
    chk("glitch_busy", bus.busy, 0);

    // Stop bit low, line held low: one frame_err, then recovery.
    send(8'h55, 1'b0, d);
    hold(1'b0, 40);
    chk("brk_busy", bus.busy, 1);
    idle(10);
    chk("brk_ferr_count", fq.size(), 1);
    if (fq.size() > 0) chk("brk_ferr_latency", fq[0] - d, HAND_LAT);
    chk("brk_no_valid", vq.size(), 0);
    chk("brk_data_kept", bus.data_out, 8'h3C);
    send(8'h12, 1'b1, d);
    idle(10);
    chk("post_brk_count", vq.size(), 1);
    if (vq.size() > 0) chk("post_brk_data", vq[0].d, 8'h12);

    // Reset during bit 4 of a frame, then a clean frame.
    hold(1'b0, CPB);
    hold(1'b0, 4 * CPB);
    hold(1'b1, 3);
    reset = 1'b1;
    hold(1'b1, 2);
    reset = 1'b0;
    idle(20);
    chk("midrst_data", bus.data_out, 8'h00);
    chk("midrst_busy", bus.busy, 0);
    vq.delete();
    fq.delete();
    send(8'h81, 1'b1, d);
    idle(10);
    chk("midrst_ferr", fq.size(), 0);
    chk("midrst_count", vq.size(), 1);
    if (vq.size() > 0) chk("midrst_81", vq[0].d, 8'h81);

`ifdef UART_RCVR_PARITY_EN
    fq.delete();
    vq.delete();
    send_p(8'h81, 1'b1, 1'b1, d);
    idle(10);
    chk("par_ferr_count", fq.size(), 1);
    if (fq.size() > 0) chk("par_ferr_latency", fq[0] - d, 87);
    chk("par_no_valid", vq.size(), 0);
    chk("par_data_kept", bus.data_out, 8'h81);
`endif

    chk("model_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
